// File: rtl/mm_ctrl_if.sv
// Bundle of the host/DMA-facing and array-facing signals of the matrix-multiply job sequencer.
interface mm_ctrl_if #(
  parameter int unsigned N = 2
) ();
  localparam int unsigned SEL_W = (N * N > 1) ? $clog2(N * N) : 1;

  // Job descriptor handshake
  logic             start_valid;
  logic             start_ready;
  logic [3:0]       cfg_precision;
  logic [4:0]       cfg_exp_set;
  logic [5:0]       cfg_k;

  // Input streams gated into the row FIFOs
  logic             act_valid;
  logic             act_ready;
  logic             w_valid;
  logic             w_ready;

  // Controls owned on the array side
  logic             mm_wr_en_act;
  logic             mm_wr_en_w;
  logic             mm_active;
  logic [3:0]       mm_precision;
  logic [4:0]       mm_exp_set;
  logic             mm_done;

  // Serial result drain
  logic [SEL_W-1:0] res_sel;
  logic             res_valid;
  logic             res_ready;
  logic             res_last;

  // Status
  logic             busy;
  logic             err;

  modport slave (
    input  start_valid, cfg_precision, cfg_exp_set, cfg_k,
    input  act_valid, w_valid, mm_done, res_ready,
    output start_ready, act_ready, w_ready,
    output mm_wr_en_act, mm_wr_en_w, mm_active, mm_precision, mm_exp_set,
    output res_sel, res_valid, res_last, busy, err
  );

  modport master (
    output start_valid, cfg_precision, cfg_exp_set, cfg_k,
    output act_valid, w_valid, mm_done, res_ready,
    input  start_ready, act_ready, w_ready,
    input  mm_wr_en_act, mm_wr_en_w, mm_active, mm_precision, mm_exp_set,
    input  res_sel, res_valid, res_last, busy, err
  );
endinterface

// File: rtl/mm_ctrl.sv
// Job sequencer for the N x N bit-serial FP-INT matrix-multiply array:
// load activation/weight beats, run until done or timeout, then drain N*N results.
module mm_ctrl #(
  parameter int unsigned N         = 2,
  parameter int unsigned ACT_DEPTH = 32,
  parameter int unsigned W_DEPTH   = 32,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned CNT_W     = 11
) (
  input  logic      clk,
  input  logic      rst,
  mm_ctrl_if.slave  bus
);

  localparam int unsigned NN       = N * N;
  localparam int unsigned SEL_W    = (NN > 1) ? $clog2(NN) : 1;
  localparam int unsigned MAX_PREC = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] act_cnt_q;
  logic [CNT_W-1:0] w_cnt_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic [CNT_W-1:0] k_tgt_q;
  logic [CNT_W-1:0] w_tgt_q;
  logic [SEL_W-1:0] idx_q;
  logic [3:0]       prec_q;
  logic [4:0]       exp_q;
  logic             start_ready_q;
  logic             act_ready_q;
  logic             w_ready_q;
  logic             active_q;
  logic             res_valid_q;
  logic             res_last_q;
  logic             busy_q;
  logic             err_q;

  logic             act_acc;
  logic             w_acc;
  logic             start_hs;
  logic             cfg_bad;
  logic [CNT_W-1:0] cfg_k_w;
  logic [CNT_W-1:0] cfg_p_w;
  logic [CNT_W-1:0] w_prod;
  logic [CNT_W-1:0] act_cnt_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic             load_done;
  logic             last_idx;

  assign act_acc  = bus.act_valid & act_ready_q;
  assign w_acc    = bus.w_valid & w_ready_q;
  assign start_hs = bus.start_valid & start_ready_q;
  assign last_idx = (idx_q == SEL_W'(NN - 1));

  // Descriptor decode and next beat counts
  always_comb begin
    cfg_k_w   = CNT_W'(bus.cfg_k);
    cfg_p_w   = CNT_W'(bus.cfg_precision);
    w_prod    = cfg_k_w * cfg_p_w;
    cfg_bad   = (cfg_k_w == '0) || (cfg_k_w > CNT_W'(ACT_DEPTH)) ||
                (cfg_p_w == '0) || (cfg_p_w > CNT_W'(MAX_PREC)) ||
                (w_prod > CNT_W'(W_DEPTH));
    act_cnt_d = act_cnt_q + CNT_W'(act_acc);
    w_cnt_d   = w_cnt_q + CNT_W'(w_acc);
    load_done = (act_cnt_d == k_tgt_q) && (w_cnt_d == w_tgt_q);
  end

  // Sequencer with every externally visible control held in a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      act_cnt_q     <= '0;
      w_cnt_q       <= '0;
      run_cnt_q     <= '0;
      k_tgt_q       <= '0;
      w_tgt_q       <= '0;
      idx_q         <= '0;
      prec_q        <= '0;
      exp_q         <= '0;
      start_ready_q <= 1'b1;
      act_ready_q   <= 1'b0;
      w_ready_q     <= 1'b0;
      active_q      <= 1'b0;
      res_valid_q   <= 1'b0;
      res_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_hs) begin
            if (cfg_bad) begin
              err_q <= 1'b1;
            end else begin
              prec_q        <= bus.cfg_precision;
              exp_q         <= bus.cfg_exp_set;
              k_tgt_q       <= cfg_k_w;
              w_tgt_q       <= w_prod;
              act_cnt_q     <= '0;
              w_cnt_q       <= '0;
              run_cnt_q     <= '0;
              idx_q         <= '0;
              act_ready_q   <= 1'b1;
              w_ready_q     <= 1'b1;
              start_ready_q <= 1'b0;
              busy_q        <= 1'b1;
              state_q       <= LOAD;
            end
          end
        end
        LOAD: begin
          act_cnt_q   <= act_cnt_d;
          w_cnt_q     <= w_cnt_d;
          act_ready_q <= (act_cnt_d < k_tgt_q);
          w_ready_q   <= (w_cnt_d < w_tgt_q);
          if (load_done) begin
            active_q <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          run_cnt_q <= run_cnt_q + CNT_W'(1);
          // done wins over a coincident timeout
          if (bus.mm_done) begin
            active_q    <= 1'b0;
            res_valid_q <= 1'b1;
            res_last_q  <= (NN == 1);
            idx_q       <= '0;
            state_q     <= DRAIN;
          end else if (run_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            active_q      <= 1'b0;
            err_q         <= 1'b1;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        DRAIN: begin
          if (res_valid_q && bus.res_ready) begin
            if (last_idx) begin
              idx_q         <= '0;
              res_valid_q   <= 1'b0;
              res_last_q    <= 1'b0;
              start_ready_q <= 1'b1;
              busy_q        <= 1'b0;
              state_q       <= IDLE;
            end else begin
              idx_q      <= idx_q + SEL_W'(1);
              res_last_q <= ((idx_q + SEL_W'(1)) == SEL_W'(NN - 1));
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready  = start_ready_q;
  assign bus.act_ready    = act_ready_q;
  assign bus.w_ready      = w_ready_q;
  assign bus.mm_wr_en_act = act_acc;
  assign bus.mm_wr_en_w   = w_acc;
  assign bus.mm_active    = active_q;
  assign bus.mm_precision = prec_q;
  assign bus.mm_exp_set   = exp_q;
  assign bus.res_sel      = idx_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_last     = res_last_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_mm_ctrl.sv
// Scoreboard bench for mm_ctrl: directed jobs push expected results/errors, a negedge monitor pops them.
module tb_mm_ctrl;
  localparam int unsigned N     = 2;
  localparam int unsigned NN    = N * N;
  localparam int unsigned SEL_W = 2;

  typedef struct packed {
    logic             is_err;
    logic [SEL_W-1:0] sel;
    logic             last;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  int   tests;
  int   fails;
  int   act_strobes;
  int   w_strobes;

  mm_ctrl_if #(.N(N)) bus ();

  mm_ctrl #(
    .N(N), .ACT_DEPTH(32), .W_DEPTH(32), .TIMEOUT(1024), .CNT_W(11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] p, input logic [4:0] e, input logic [5:0] k, input bit bad);
    bus.cfg_precision = p;
    bus.cfg_exp_set   = e;
    bus.cfg_k         = k;
    bus.start_valid   = 1'b1;
    if (bad) sb_q.push_back('{1'b1, SEL_W'(0), 1'b0});
    tick();
    bus.start_valid = 1'b0;
  endtask

  // Feed both streams until mm_active rises; verify beat counts and rise timing
  task automatic load(input bit rnd, input int k, input int wt);
    bit prev_beat;
    bit seen;
    int a0;
    int w0;
    a0 = act_strobes;
    w0 = w_strobes;
    prev_beat = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (bus.mm_active) begin
        seen = 1'b1;
        break;
      end
      bus.act_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.w_valid   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      prev_beat = bus.mm_wr_en_act | bus.mm_wr_en_w;
      tick();
    end
    bus.act_valid = 1'b0;
    bus.w_valid   = 1'b0;
    check("load_reaches_run", int'(seen), 1);
    check("active_one_cycle_after_last_beat", int'(prev_beat), 1);
    check("act_beats", act_strobes - a0, k);
    check("w_beats", w_strobes - w0, wt);
  endtask

  // Assert done after done_delay RUN cycles, then drain with an optional stall at stall_idx
  task automatic run_drain(input int done_delay, input int stall_idx, input int stall_len);
    int e;
    int stalled;
    for (int i = 0; i < done_delay; i++) tick();
    check("active_before_done", int'(bus.mm_active), 1);
    bus.mm_done = 1'b1;
    for (int i = 0; i < NN; i++) sb_q.push_back('{1'b0, SEL_W'(i), (i == NN - 1)});
    tick();
    bus.mm_done = 1'b0;
    check("active_drops_on_done", int'(bus.mm_active), 0);
    e = 0;
    stalled = 0;
    for (int cyc = 0; cyc < 50 && e < NN; cyc++) begin
      check("res_valid", int'(bus.res_valid), 1);
      check("res_sel", int'(bus.res_sel), e);
      check("res_last", int'(bus.res_last), int'(e == NN - 1));
      if (e == stall_idx && stalled < stall_len) begin
        bus.res_ready = 1'b0;
        stalled++;
      end else begin
        bus.res_ready = 1'b1;
        e++;
      end
      tick();
    end
    bus.res_ready = 1'b0;
    check("drain_complete", e, NN);
    check("start_ready_after_drain", int'(bus.start_ready), 1);
    check("busy_after_drain", int'(bus.busy), 0);
    check("res_valid_after_drain", int'(bus.res_valid), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, int'(bus.start_ready), 1);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_act_ready"}, int'(bus.act_ready), 0);
    check({tag, "_w_ready"}, int'(bus.w_ready), 0);
    check({tag, "_wr_en_act"}, int'(bus.mm_wr_en_act), 0);
    check({tag, "_mm_active"}, int'(bus.mm_active), 0);
    check({tag, "_precision"}, int'(bus.mm_precision), 0);
    check({tag, "_exp_set"}, int'(bus.mm_exp_set), 0);
    check({tag, "_res_valid"}, int'(bus.res_valid), 0);
    check({tag, "_res_sel"}, int'(bus.res_sel), 0);
    check({tag, "_err"}, int'(bus.err), 0);
  endtask

  initial begin
    int s_a;
    int s_w;
    tests = 0;
    fails = 0;
    act_strobes = 0;
    w_strobes = 0;
    rst = 1'b0;
    bus.start_valid = 1'b0;
    bus.cfg_precision = '0;
    bus.cfg_exp_set = '0;
    bus.cfg_k = '0;
    bus.act_valid = 1'b0;
    bus.w_valid = 1'b0;
    bus.mm_done = 1'b0;
    bus.res_ready = 1'b0;

    fork
      begin : monitor
        exp_t x;
        forever begin
          @(negedge clk);
          if (bus.mm_wr_en_act) begin
            act_strobes++;
            check("act_strobe_needs_valid", int'(bus.act_valid), 1);
          end
          if (bus.mm_wr_en_w) begin
            w_strobes++;
            check("w_strobe_needs_valid", int'(bus.w_valid), 1);
          end
          if (bus.err) begin
            if (sb_q.size() == 0) check("unexpected_err", 1, 0);
            else begin
              x = sb_q.pop_front();
              check("sb_err_expected", int'(x.is_err), 1);
            end
          end
          if (bus.res_valid && bus.res_ready) begin
            if (sb_q.size() == 0) check("unexpected_result", 1, 0);
            else begin
              x = sb_q.pop_front();
              check("sb_result_expected", int'(x.is_err), 0);
              check("sb_res_sel", int'(bus.res_sel), int'(x.sel));
              check("sb_res_last", int'(bus.res_last), int'(x.last));
            end
          end
        end
      end
    join_none

    // Reset values, asserted asynchronously before the first edge
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Job 1: always-valid streams, done 7 cycles into RUN, free-flowing drain
    issue(4'd4, 5'd15, 6'd3, 1'b0);
    check("load_busy", int'(bus.busy), 1);
    check("load_start_ready", int'(bus.start_ready), 0);
    check("load_precision", int'(bus.mm_precision), 4);
    check("load_exp_set", int'(bus.mm_exp_set), 15);
    load(1'b0, 3, 12);
    run_drain(7, -1, 0);

    // Job 2: random stream valids, stall 5 cycles at idx 1; a busy-time descriptor must not be consumed
    issue(4'd4, 5'd15, 6'd3, 1'b0);
    bus.cfg_k = 6'd0;
    bus.start_valid = 1'b1;
    load(1'b1, 3, 12);
    check("busy_start_ready_low", int'(bus.start_ready), 0);
    run_drain(2, 1, 5);
    bus.start_valid = 1'b0;

    // Bad descriptors: one err pulse each, no state change, no strobes
    bus.act_valid = 1'b1;
    bus.w_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      s_a = act_strobes;
      s_w = w_strobes;
      case (t)
        0: issue(4'd4, 5'd1, 6'd0, 1'b1);
        1: issue(4'd9, 5'd1, 6'd3, 1'b1);
        2: issue(4'd8, 5'd1, 6'd8, 1'b1);
        3: issue(4'd0, 5'd1, 6'd1, 1'b1);
        default: issue(4'd1, 5'd1, 6'd33, 1'b1);
      endcase
      check("bad_err_pulse", int'(bus.err), 1);
      check("bad_busy", int'(bus.busy), 0);
      check("bad_start_ready", int'(bus.start_ready), 1);
      tick();
      check("bad_err_single", int'(bus.err), 0);
      check("bad_no_act_strobe", act_strobes - s_a, 0);
      check("bad_no_w_strobe", w_strobes - s_w, 0);
    end
    bus.act_valid = 1'b0;
    bus.w_valid = 1'b0;

    // Timeout: no done, RUN lasts exactly 1024 cycles then err
    issue(4'd1, 5'd0, 6'd1, 1'b0);
    sb_q.push_back('{1'b1, SEL_W'(0), 1'b0});
    load(1'b0, 1, 1);
    s_a = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!bus.mm_active) break;
      s_a++;
      tick();
    end
    check("timeout_run_cycles", s_a, 1024);
    check("timeout_err", int'(bus.err), 1);
    check("timeout_busy", int'(bus.busy), 0);
    tick();

    // mm_done in IDLE is ignored
    bus.mm_done = 1'b1;
    tick();
    bus.mm_done = 1'b0;
    tick();
    check("idle_done_busy", int'(bus.busy), 0);
    check("idle_done_res_valid", int'(bus.res_valid), 0);

    // Asynchronous reset mid-LOAD, then a clean job
    issue(4'd4, 5'd3, 6'd2, 1'b0);
    bus.act_valid = 1'b1;
    bus.w_valid = 1'b1;
    tick();
    check("midload_busy", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midload_rst");
    bus.act_valid = 1'b0;
    bus.w_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    issue(4'd2, 5'd7, 6'd4, 1'b0);
    check("after_rst_precision", int'(bus.mm_precision), 2);
    check("after_rst_exp_set", int'(bus.mm_exp_set), 7);
    load(1'b0, 4, 8);
    run_drain(0, 3, 2);

    tick();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
